// File: rtl/traffic_pkg.sv
// Shared types and constants for the actuated four-way intersection phase scheduler.
// Lamp vectors are ordered {ns_green, ns_left_green, ns_yellow, ns_red, ew_green, ew_left_green, ew_yellow, ew_red}.
package traffic_pkg;

  typedef enum logic [3:0] {
    INIT_RED  = 4'd0,
    NS_LEFT   = 4'd1,
    NS_GREEN  = 4'd2,
    NS_YELLOW = 4'd3,
    NS_CLEAR  = 4'd4,
    EW_LEFT   = 4'd5,
    EW_GREEN  = 4'd6,
    EW_YELLOW = 4'd7,
    EW_CLEAR  = 4'd8
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  localparam logic [7:0] LAMPS_INIT_RED  = 8'b0001_0001;
  localparam logic [7:0] LAMPS_NS_LEFT   = 8'b0101_0001;
  localparam logic [7:0] LAMPS_NS_GREEN  = 8'b1000_0001;
  localparam logic [7:0] LAMPS_NS_YELLOW = 8'b0010_0001;
  localparam logic [7:0] LAMPS_NS_CLEAR  = 8'b0001_0001;
  localparam logic [7:0] LAMPS_EW_LEFT   = 8'b0001_0101;
  localparam logic [7:0] LAMPS_EW_GREEN  = 8'b0001_1000;
  localparam logic [7:0] LAMPS_EW_YELLOW = 8'b0001_0010;
  localparam logic [7:0] LAMPS_EW_CLEAR  = 8'b0001_0001;

  function automatic logic [7:0] lamps_of(input state_t s);
    logic [7:0] v;
    case (s)
      INIT_RED:  v = LAMPS_INIT_RED;
      NS_LEFT:   v = LAMPS_NS_LEFT;
      NS_GREEN:  v = LAMPS_NS_GREEN;
      NS_YELLOW: v = LAMPS_NS_YELLOW;
      NS_CLEAR:  v = LAMPS_NS_CLEAR;
      EW_LEFT:   v = LAMPS_EW_LEFT;
      EW_GREEN:  v = LAMPS_EW_GREEN;
      EW_YELLOW: v = LAMPS_EW_YELLOW;
      EW_CLEAR:  v = LAMPS_EW_CLEAR;
      default:   v = LAMPS_INIT_RED;
    endcase
    return v;
  endfunction

  function automatic state_t green_of(input logic dir);
    state_t s;
    if (dir == DIR_EW) s = EW_GREEN;
    else s = NS_GREEN;
    return s;
  endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// Detector inputs and lamp/status outputs of the phase scheduler.
// The scheduler takes the slave side; the cabinet/controller side takes master.
interface traffic_phase_sched_if;
  logic       ns_car_req;
  logic       ew_car_req;
  logic       ns_left_req;
  logic       ew_left_req;
  logic       preempt_req;
  logic       preempt_dir;
  logic       ns_green;
  logic       ns_left_green;
  logic       ns_yellow;
  logic       ns_red;
  logic       ew_green;
  logic       ew_left_green;
  logic       ew_yellow;
  logic       ew_red;
  logic [3:0] phase;
  logic       preempt_active;

  modport master (
    output ns_car_req, ew_car_req, ns_left_req, ew_left_req, preempt_req, preempt_dir,
    input  ns_green, ns_left_green, ns_yellow, ns_red,
    input  ew_green, ew_left_green, ew_yellow, ew_red, phase, preempt_active
  );

  modport slave (
    input  ns_car_req, ew_car_req, ns_left_req, ew_left_req, preempt_req, preempt_dir,
    output ns_green, ns_left_green, ns_yellow, ns_red,
    output ew_green, ew_left_green, ew_yellow, ew_red, phase, preempt_active
  );
endinterface

// File: rtl/traffic_phase_sched_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 and pulses tick for one clk on the last count.
module tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_r;
  logic [PW-1:0] cnt_next_s;
  logic          tick_r;

  // Next prescaler count with wrap at the last count.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == LAST) cnt_next_s = '0;
    else cnt_next_s = cnt_r + PW'(1);
  end

  // Prescaler and registered tick; tick_r tracks (cnt_r == LAST).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= (TICK_DIV == 1);
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == LAST);
    end
  end

  assign tick = tick_r;
endmodule

// File: rtl/traffic_phase_sched.sv
// Actuated phase scheduler for a four-way intersection: latched demands, min/max green,
// left-phase skipping, rest-in-green and emergency preemption.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int MIN_GREEN  = 5,
  parameter int MAX_GREEN  = 20,
  parameter int LEFT_GREEN = 4,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  traffic_phase_sched_if.slave bus
);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(LEFT_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(ALL_RED - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] timer_r;
  logic             tick_s;
  logic             ns_car_r, ew_car_r, ns_left_r, ew_left_r;
  logic             pre_act_r, pre_dir_r;
  logic             pre_ns_s, pre_ew_s, pre_rel_s;
  logic             min_done_s, max_done_s, left_done_s, yellow_done_s, clear_done_s;
  logic             ns_dem_s, ew_dem_s;
  logic [7:0]       lamps_next_s;
  logic [7:0]       lamps_r;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  assign pre_ns_s      = pre_act_r && (pre_dir_r == DIR_NS);
  assign pre_ew_s      = pre_act_r && (pre_dir_r == DIR_EW);
  assign pre_rel_s     = pre_act_r && !bus.preempt_req && tick_s && (state_r == green_of(pre_dir_r));
  assign min_done_s    = (timer_r >= MIN_LAST);
  assign max_done_s    = (timer_r >= MAX_LAST);
  assign left_done_s   = (timer_r == LEFT_LAST);
  assign yellow_done_s = (timer_r == YELLOW_LAST);
  assign clear_done_s  = (timer_r == CLEAR_LAST);
  assign ns_dem_s      = ns_car_r || ns_left_r;
  assign ew_dem_s      = ew_car_r || ew_left_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= INIT_RED;
    else state_r <= state_next_s;
  end

  // Next-state logic; all transitions happen on a tick. An own-direction through
  // demand extends green past MIN up to MAX while cross demand waits.
  always_comb begin
    state_next_s = state_r;
    if (tick_s) begin
      case (state_r)
        INIT_RED: begin
          if (!clear_done_s) state_next_s = state_r;
          else if (pre_act_r) state_next_s = green_of(pre_dir_r);
          else if (ns_left_r) state_next_s = NS_LEFT;
          else state_next_s = NS_GREEN;
        end
        NS_LEFT: begin
          if (pre_ew_s) state_next_s = NS_YELLOW;
          else if (pre_ns_s || left_done_s) state_next_s = NS_GREEN;
          else state_next_s = state_r;
        end
        NS_GREEN: begin
          if (pre_ew_s) state_next_s = NS_YELLOW;
          else if (pre_ns_s) state_next_s = state_r;
          else if (ew_dem_s && ((min_done_s && !ns_car_r) || max_done_s)) state_next_s = NS_YELLOW;
          else state_next_s = state_r;
        end
        NS_YELLOW: begin
          if (yellow_done_s) state_next_s = NS_CLEAR;
          else state_next_s = state_r;
        end
        NS_CLEAR: begin
          if (!clear_done_s) state_next_s = state_r;
          else if (pre_act_r) state_next_s = green_of(pre_dir_r);
          else if (ew_left_r) state_next_s = EW_LEFT;
          else state_next_s = EW_GREEN;
        end
        EW_LEFT: begin
          if (pre_ns_s) state_next_s = EW_YELLOW;
          else if (pre_ew_s || left_done_s) state_next_s = EW_GREEN;
          else state_next_s = state_r;
        end
        EW_GREEN: begin
          if (pre_ns_s) state_next_s = EW_YELLOW;
          else if (pre_ew_s) state_next_s = state_r;
          else if (ns_dem_s && ((min_done_s && !ew_car_r) || max_done_s)) state_next_s = EW_YELLOW;
          else state_next_s = state_r;
        end
        EW_YELLOW: begin
          if (yellow_done_s) state_next_s = EW_CLEAR;
          else state_next_s = state_r;
        end
        EW_CLEAR: begin
          if (!clear_done_s) state_next_s = state_r;
          else if (pre_act_r) state_next_s = green_of(pre_dir_r);
          else if (ns_left_r) state_next_s = NS_LEFT;
          else state_next_s = NS_GREEN;
        end
        default: state_next_s = INIT_RED;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Lamp decode of the upcoming state so the registered lamps move with the state.
  always_comb begin
    lamps_next_s = lamps_of(state_next_s);
  end

  // Registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lamps_r <= LAMPS_INIT_RED;
    else lamps_r <= lamps_next_s;
  end

  // Phase timer: restarts on any state change and on preemption release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer_r <= '0;
    else if ((state_next_s != state_r) || pre_rel_s) timer_r <= '0;
    else if (tick_s && (timer_r != {CNT_W{1'b1}})) timer_r <= timer_r + CNT_W'(1);
  end

  // Sticky demand latches; a detector still asserted on the clearing edge keeps its latch set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_car_r  <= 1'b0;
      ew_car_r  <= 1'b0;
      ns_left_r <= 1'b0;
      ew_left_r <= 1'b0;
    end else begin
      ns_car_r  <= bus.ns_car_req  || (ns_car_r  && !((state_next_s == NS_GREEN) && (state_r != NS_GREEN)));
      ew_car_r  <= bus.ew_car_req  || (ew_car_r  && !((state_next_s == EW_GREEN) && (state_r != EW_GREEN)));
      ns_left_r <= bus.ns_left_req || (ns_left_r && !((state_next_s == NS_LEFT)  && (state_r != NS_LEFT)));
      ew_left_r <= bus.ew_left_req || (ew_left_r && !((state_next_s == EW_LEFT)  && (state_r != EW_LEFT)));
    end
  end

  // Preemption sequence flag; direction is frozen for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_act_r <= 1'b0;
      pre_dir_r <= DIR_NS;
    end else if (!pre_act_r && bus.preempt_req) begin
      pre_act_r <= 1'b1;
      pre_dir_r <= bus.preempt_dir;
    end else if (pre_rel_s) begin
      pre_act_r <= 1'b0;
    end
  end

  assign {bus.ns_green, bus.ns_left_green, bus.ns_yellow, bus.ns_red,
          bus.ew_green, bus.ew_left_green, bus.ew_yellow, bus.ew_red} = lamps_r;
  assign bus.phase          = state_r;
  assign bus.preempt_active = pre_act_r;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched with TICK_DIV=2, MIN=4, MAX=8, LEFT=3, YELLOW=2, ALL_RED=1.
module tb_traffic_phase_sched;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;
  int   inv_bad = 0;

  traffic_phase_sched_if bus ();

  traffic_phase_sched #(
    .TICK_DIV(2), .MIN_GREEN(4), .MAX_GREEN(8), .LEFT_GREEN(3),
    .YELLOW(2), .ALL_RED(1), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lamps_now();
    return {bus.ns_green, bus.ns_left_green, bus.ns_yellow, bus.ns_red,
            bus.ew_green, bus.ew_left_green, bus.ew_yellow, bus.ew_red};
  endfunction

  // Lamp sanity monitor sampled every negedge outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((int'(bus.ns_green) + int'(bus.ns_yellow) + int'(bus.ns_red)) != 1) inv_bad++;
      if ((int'(bus.ew_green) + int'(bus.ew_yellow) + int'(bus.ew_red)) != 1) inv_bad++;
      if (bus.ns_green && bus.ew_green) inv_bad++;
      if (bus.ns_left_green && !bus.ns_red) inv_bad++;
      if (bus.ew_left_green && !bus.ew_red) inv_bad++;
    end
  end

  // Counts negedge samples (including the current one) while phase stays at p.
  task automatic dwell(input logic [3:0] p, input int budget, output int n);
    n = 0;
    while ((bus.phase == p) && (n < budget)) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Pulses reset and returns at the first sample after INIT_RED.
  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dwell(INIT_RED, 10, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ns_car_req = 1'b0; bus.ew_car_req = 1'b0;
    bus.ns_left_req = 1'b0; bus.ew_left_req = 1'b0;
    bus.preempt_req = 1'b0; bus.preempt_dir = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.phase !== INIT_RED) $display("FAIL reset_phase: got %0d want %0d", bus.phase, INIT_RED); else passed++;
    checks++; if (lamps_now() !== 8'b0001_0001) $display("FAIL reset_lamps: got %b want 00010001", lamps_now()); else passed++;
    checks++; if (bus.preempt_active !== 1'b0) $display("FAIL reset_preempt: got %b want 0", bus.preempt_active); else passed++;
  endtask

  task automatic test_rest_in_green();
    int n;
    int bad;
    rst_n = 1'b1;
    dwell(INIT_RED, 10, n);
    checks++; if (n !== 2) $display("FAIL init_red_len: got %0d want 2", n); else passed++;
    checks++; if (bus.phase !== NS_GREEN) $display("FAIL rest_phase: got %0d want %0d", bus.phase, NS_GREEN); else passed++;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (!(bus.ns_green === 1'b1 && bus.ew_red === 1'b1 && bus.phase == NS_GREEN)) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) $display("FAIL rest_hold: got %0d bad cycles want 0", bad); else passed++;
  endtask

  task automatic test_gap_out();
    int n;
    do_reset();
    bus.ew_car_req = 1'b1;
    @(negedge clk);
    bus.ew_car_req = 1'b0;
    dwell(NS_GREEN, 40, n);
    checks++; if (n + 1 !== 8) $display("FAIL gap_green_len: got %0d want 8", n + 1); else passed++;
    dwell(NS_YELLOW, 20, n);
    checks++; if (n !== 4) $display("FAIL gap_yellow_len: got %0d want 4", n); else passed++;
    dwell(NS_CLEAR, 20, n);
    checks++; if (n !== 2) $display("FAIL gap_clear_len: got %0d want 2", n); else passed++;
    checks++; if (bus.phase !== EW_GREEN) $display("FAIL gap_next: got %0d want %0d", bus.phase, EW_GREEN); else passed++;
    checks++; if (lamps_now() !== 8'b0001_1000) $display("FAIL gap_lamps: got %b want 00011000", lamps_now()); else passed++;
    checks++; if (dut.ew_car_r !== 1'b0) $display("FAIL gap_latch_clear: got %b want 0", dut.ew_car_r); else passed++;
  endtask

  task automatic test_back_to_back();
    int g1, y1, c1, g2, y2, c2;
    bus.ns_car_req = 1'b1;
    bus.ew_car_req = 1'b1;
    do_reset();
    dwell(NS_GREEN, 60, g1);
    dwell(NS_YELLOW, 20, y1);
    dwell(NS_CLEAR, 20, c1);
    dwell(EW_GREEN, 60, g2);
    dwell(EW_YELLOW, 20, y2);
    dwell(EW_CLEAR, 20, c2);
    checks++; if (g1 !== 16) $display("FAIL b2b_ns_green: got %0d want 16", g1); else passed++;
    checks++; if (g2 !== 16) $display("FAIL b2b_ew_green: got %0d want 16", g2); else passed++;
    checks++; if (g1 + y1 + c1 + g2 + y2 + c2 !== 44) $display("FAIL b2b_period: got %0d want 44", g1 + y1 + c1 + g2 + y2 + c2); else passed++;
    checks++; if (bus.phase !== NS_GREEN) $display("FAIL b2b_wrap: got %0d want %0d", bus.phase, NS_GREEN); else passed++;
    bus.ns_car_req = 1'b0;
    bus.ew_car_req = 1'b0;
  endtask

  task automatic test_left_phase();
    int n;
    do_reset();
    bus.ew_left_req = 1'b1;
    @(negedge clk);
    bus.ew_left_req = 1'b0;
    dwell(NS_GREEN, 40, n);
    checks++; if (n + 1 !== 8) $display("FAIL left_ns_green_len: got %0d want 8", n + 1); else passed++;
    dwell(NS_YELLOW, 20, n);
    dwell(NS_CLEAR, 20, n);
    checks++; if (bus.phase !== EW_LEFT) $display("FAIL left_phase: got %0d want %0d", bus.phase, EW_LEFT); else passed++;
    checks++; if (lamps_now() !== 8'b0001_0101) $display("FAIL left_lamps: got %b want 00010101", lamps_now()); else passed++;
    dwell(EW_LEFT, 20, n);
    checks++; if (n !== 6) $display("FAIL left_len: got %0d want 6", n); else passed++;
    checks++; if (bus.phase !== EW_GREEN) $display("FAIL left_next: got %0d want %0d", bus.phase, EW_GREEN); else passed++;
    checks++; if (dut.ew_left_r !== 1'b0) $display("FAIL left_latch_clear: got %b want 0", dut.ew_left_r); else passed++;
  endtask

  task automatic test_preempt();
    int n;
    int bad;
    do_reset();
    bus.preempt_dir = 1'b1;
    bus.preempt_req = 1'b1;
    bus.ew_left_req = 1'b1;
    dwell(NS_GREEN, 20, n);
    checks++; if (n !== 2) $display("FAIL pre_cut_green: got %0d want 2", n); else passed++;
    checks++; if (bus.preempt_active !== 1'b1) $display("FAIL pre_active_set: got %b want 1", bus.preempt_active); else passed++;
    dwell(NS_YELLOW, 20, n);
    checks++; if (n !== 4) $display("FAIL pre_yellow_len: got %0d want 4", n); else passed++;
    dwell(NS_CLEAR, 20, n);
    checks++; if (bus.phase !== EW_GREEN) $display("FAIL pre_skip_left: got %0d want %0d", bus.phase, EW_GREEN); else passed++;
    bus.preempt_dir = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.phase != EW_GREEN || bus.preempt_active !== 1'b1) bad++;
      bus.ns_car_req = (i == 0);
      @(negedge clk);
    end
    checks++; if (bad !== 0) $display("FAIL pre_hold: got %0d bad cycles want 0", bad); else passed++;
    bus.preempt_req = 1'b0;
    n = 0;
    while (bus.preempt_active === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 2) $display("FAIL pre_release_delay: got %0d want 2", n); else passed++;
    dwell(EW_GREEN, 40, n);
    checks++; if (n !== 8) $display("FAIL pre_min_after: got %0d want 8", n); else passed++;
    checks++; if (bus.phase !== EW_YELLOW) $display("FAIL pre_exit: got %0d want %0d", bus.phase, EW_YELLOW); else passed++;
    bus.ew_left_req = 1'b0;
  endtask

  task automatic test_reset_mid_yellow();
    bus.preempt_dir = 1'b0;
    bus.preempt_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.phase !== EW_YELLOW) $display("FAIL mid_setup: got %0d want %0d", bus.phase, EW_YELLOW); else passed++;
    checks++; if (bus.preempt_active !== 1'b1) $display("FAIL mid_pre_set: got %b want 1", bus.preempt_active); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.phase !== INIT_RED) $display("FAIL mid_phase: got %0d want %0d", bus.phase, INIT_RED); else passed++;
    checks++; if (lamps_now() !== 8'b0001_0001) $display("FAIL mid_lamps: got %b want 00010001", lamps_now()); else passed++;
    checks++; if (bus.preempt_active !== 1'b0) $display("FAIL mid_preempt: got %b want 0", bus.preempt_active); else passed++;
    bus.preempt_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lamp_invariants();
    checks++; if (inv_bad !== 0) $display("FAIL lamp_invariants: got %0d violations want 0", inv_bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_rest_in_green();
    test_gap_out();
    test_back_to_back();
    test_left_phase();
    test_preempt();
    test_reset_mid_yellow();
    test_lamp_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
